// File: rtl/reg_bank_user_if.sv
// Bus bundle for reg_bank_user: write, read and sweep controls in; read data and status out.
// Latency: none (wires only).
// Backpressure: none; busy and ovr report dropped or deferred work.
interface reg_bank_user_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 3
);
  logic             E;
  logic [1:0]       MODE;
  logic [AW-1:0]    WADDR;
  logic [WIDTH-1:0] data;
  logic             RE;
  logic [AW-1:0]    RADDR;
  logic             CLR_ALL;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             ovr;

  modport master (
    output E, MODE, WADDR, data, RE, RADDR, CLR_ALL,
    input  q, q_valid, busy, ovr
  );

  modport slave (
    input  E, MODE, WADDR, data, RE, RADDR, CLR_ALL,
    output q, q_valid, busy, ovr
  );
endinterface

// File: rtl/reg_bank_user.sv
// Multi-entry user register bank: per-write modes (LOAD/CLEAR/SHL/INC), registered read port, bulk-clear sweep.
// Latency: write visible to a read sampled one edge later; read data 1 cycle after RE; sweep takes DEPTH cycles.
// Backpressure: none; writes during a sweep, with CLR_ALL, or out of range are dropped and flagged on sticky ovr.
// Optional feature: define REG_BANK_SAT_EN to make INC saturate at all-ones instead of wrapping.
module reg_bank_user #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           CLK,
  input  logic           R,
  reg_bank_user_if.slave bus
);
  // Storage covers the full address space so any AW-bit index stays in range;
  // entries at or above DEPTH are never written and keep their reset value.
  localparam int               NSLOT    = 1 << AW;
  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_CLEAR = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] mem [NSLOT];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] wr_val;
  logic             waddr_ok;
  logic             raddr_ok;
  logic             wr_ok;
  logic             wr_drop;

  assign waddr_ok = {1'b0, bus.WADDR} < DEPTH_W;
  assign raddr_ok = {1'b0, bus.RADDR} < DEPTH_W;
  // CLR_ALL takes priority over a same-cycle write; sweeping blocks all writes.
  assign wr_ok    = bus.E && !bus.CLR_ALL && (state == IDLE) && waddr_ok;
  assign wr_drop  = bus.E && !wr_ok;
  assign cur      = mem[bus.WADDR];

  // Next value of the addressed entry for the selected write mode.
  always_comb begin
    wr_val = bus.data;
    case (bus.MODE)
      MODE_LOAD:  wr_val = bus.data;
      MODE_CLEAR: wr_val = '0;
      MODE_SHL:   wr_val = {cur[WIDTH-2:0], bus.data[0]};
      default: begin
`ifdef REG_BANK_SAT_EN
        wr_val = (&cur) ? cur : cur + ONE;
`else
        wr_val = cur + ONE;
`endif
      end
    endcase
  end

  // Sweep FSM: walk idx over every entry once, busy mirrors the SWEEP state.
  always_ff @(posedge CLK) begin
    if (!R) begin
      state    <= IDLE;
      idx      <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CLR_ALL) begin
            state    <= SWEEP;
            idx      <= '0;
            bus.busy <= 1'b1;
          end
        end
        SWEEP: begin
          idx <= idx + IDX_ONE;
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: reset clears all, sweep clears one entry per cycle, else accepted writes.
  always_ff @(posedge CLK) begin
    if (!R) begin
      for (int i = 0; i < NSLOT; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[bus.WADDR] <= wr_val;
    end
  end

  // Registered read port; sees pre-write contents, out-of-range reads return zero.
  always_ff @(posedge CLK) begin
    if (!R) begin
      bus.q       <= '0;
      bus.q_valid <= 1'b0;
    end else if (bus.RE) begin
      bus.q       <= raddr_ok ? mem[bus.RADDR] : '0;
      bus.q_valid <= 1'b1;
    end else begin
      bus.q_valid <= 1'b0;
    end
  end

  // Sticky overrun flag, set on the edge that drops a write.
  always_ff @(posedge CLK) begin
    if (!R) begin
      bus.ovr <= 1'b0;
    end else if (wr_drop) begin
      bus.ovr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_bank_user.sv
// Self-checking bench for reg_bank_user: vector table plus sweep/reset/range sequences.
// Read results are scored from a queue of expected values pushed when RE is driven.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
`timescale 1ns/1ps
module tb_reg_bank_user;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int NV    = 21;

  localparam logic [1:0] M_LOAD  = 2'b00;
  localparam logic [1:0] M_CLEAR = 2'b01;
  localparam logic [1:0] M_SHL   = 2'b10;
  localparam logic [1:0] M_INC   = 2'b11;

  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] PAT   = 64'h0123_4567_89AB_CDEF;
`ifdef REG_BANK_SAT_EN
  localparam logic [WIDTH-1:0] INC_OF_ONES = '1;
`else
  localparam logic [WIDTH-1:0] INC_OF_ONES = '0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  reg_bank_user_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  reg_bank_user #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK (clk),
    .R   (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             e;
    logic [1:0]       mode;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] data;
    logic             re;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] exp_q;
    logic             exp_ovr;
  } vec_t;

  vec_t             vecs [NV];
  logic [WIDTH-1:0] exp_q_fifo [$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               busy_cnt;

  function automatic vec_t mk(input logic e, input logic [1:0] mode, input logic [AW-1:0] waddr,
                              input logic [WIDTH-1:0] data, input logic re, input logic [AW-1:0] raddr,
                              input logic [WIDTH-1:0] exp_q, input logic exp_ovr);
    vec_t v;
    v.e = e; v.mode = mode; v.waddr = waddr; v.data = data;
    v.re = re; v.raddr = raddr; v.exp_q = exp_q; v.exp_ovr = exp_ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.E       = 1'b0;
    bus.MODE    = M_LOAD;
    bus.WADDR   = '0;
    bus.data    = '0;
    bus.RE      = 1'b0;
    bus.RADDR   = '0;
    bus.CLR_ALL = 1'b0;
  endtask

  task automatic drive_write(input logic [1:0] mode, input logic [AW-1:0] addr, input logic [WIDTH-1:0] d);
    bus.E     = 1'b1;
    bus.MODE  = mode;
    bus.WADDR = addr;
    bus.data  = d;
  endtask

  task automatic drive_read(input logic [AW-1:0] addr, input logic [WIDTH-1:0] exp);
    bus.RE    = 1'b1;
    bus.RADDR = addr;
    exp_q_fifo.push_back(exp);
  endtask

  // Advance one edge, then score the read port against the expected-value queue.
  task automatic tick(input string tag);
    logic             rd_now;
    logic [WIDTH-1:0] exp;
    rd_now = bus.RE && rst_n;
    @(posedge clk);
    #1;
    if (rd_now) begin
      check({tag, " q_valid"}, WIDTH'(bus.q_valid), ONE64(1'b1));
      exp = (exp_q_fifo.size() != 0) ? exp_q_fifo.pop_front() : ~bus.q;
      check({tag, " q"}, bus.q, exp);
    end else begin
      check({tag, " q_valid"}, WIDTH'(bus.q_valid), ONE64(1'b0));
    end
    idle_inputs();
  endtask

  function automatic logic [WIDTH-1:0] ONE64(input logic b);
    return WIDTH'(b);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset q",       bus.q,               ZERO);
    check("reset q_valid", WIDTH'(bus.q_valid), ZERO);
    check("reset busy",    WIDTH'(bus.busy),    ZERO);
    check("reset ovr",     WIDTH'(bus.ovr),     ZERO);
    rst_n = 1'b1;

    // {e, mode, waddr, data, re, raddr, expected q, expected ovr}
    vecs[0]  = mk(1, M_LOAD,  3, PAT,                   0, 0, ZERO,  0);
    vecs[1]  = mk(0, M_LOAD,  0, ZERO,                  1, 3, PAT,   0);
    vecs[2]  = mk(0, M_LOAD,  0, ZERO,                  0, 0, ZERO,  0);
    vecs[3]  = mk(1, M_LOAD,  0, 64'h1,                 0, 0, ZERO,  0);
    vecs[4]  = mk(1, M_SHL,   0, 64'h1,                 0, 0, ZERO,  0);
    vecs[5]  = mk(1, M_SHL,   0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, ZERO, 0);
    vecs[6]  = mk(1, M_SHL,   0, 64'h1,                 1, 0, 64'h6, 0);
    vecs[7]  = mk(0, M_LOAD,  0, ZERO,                  1, 0, 64'hD, 0);
    vecs[8]  = mk(1, M_INC,   0, ZERO,                  1, 0, 64'hD, 0);
    vecs[9]  = mk(0, M_LOAD,  0, ZERO,                  1, 0, 64'hE, 0);
    vecs[10] = mk(1, M_LOAD,  5, ONES,                  0, 0, ZERO,  0);
    vecs[11] = mk(1, M_INC,   5, ZERO,                  0, 0, ZERO,  0);
    vecs[12] = mk(0, M_LOAD,  0, ZERO,                  1, 5, INC_OF_ONES, 0);
    vecs[13] = mk(1, M_LOAD,  2, 64'h55,                0, 0, ZERO,  0);
    vecs[14] = mk(1, M_LOAD,  2, 64'hAA,                1, 2, 64'h55, 0);
    vecs[15] = mk(0, M_LOAD,  0, ZERO,                  1, 2, 64'hAA, 0);
    vecs[16] = mk(1, M_CLEAR, 3, ONES,                  1, 3, PAT,   0);
    vecs[17] = mk(0, M_LOAD,  0, ZERO,                  1, 3, ZERO,  0);
    vecs[18] = mk(0, M_LOAD,  0, ZERO,                  1, 9, ZERO,  0);
    vecs[19] = mk(1, M_INC,   6, ZERO,                  1, 6, ZERO,  0);
    vecs[20] = mk(0, M_LOAD,  0, ZERO,                  1, 6, 64'h1, 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].e)  drive_write(vecs[i].mode, vecs[i].waddr, vecs[i].data);
      if (vecs[i].re) drive_read(vecs[i].raddr, vecs[i].exp_q);
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d ovr", i), WIDTH'(bus.ovr), WIDTH'(vecs[i].exp_ovr));
    end

    // Bulk clear: fill every entry, sweep, poke writes/reads/CLR_ALL while busy.
    for (int i = 0; i < DEPTH; i++) begin
      drive_write(M_LOAD, AW'(i), 64'h100 + WIDTH'(i));
      tick($sformatf("fill%0d", i));
    end
    check("ovr before sweep", WIDTH'(bus.ovr), ZERO);
    bus.CLR_ALL = 1'b1;
    tick("clr_start");
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 20) begin
      busy_cnt++;
      if (busy_cnt == 1) drive_write(M_LOAD, 0, 64'hDEAD);
      if (busy_cnt == 2) drive_read(7, 64'h107);
      if (busy_cnt == 3) begin
        bus.CLR_ALL = 1'b1;
        drive_read(0, ZERO);
      end
      tick($sformatf("sweep%0d", busy_cnt));
      if (busy_cnt == 1) check("ovr on drop edge", WIDTH'(bus.ovr), ONE64(1'b1));
    end
    check("busy cycles", WIDTH'(busy_cnt), WIDTH'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      drive_read(AW'(i), ZERO);
      tick($sformatf("post_sweep%0d", i));
    end
    check("ovr sticky", WIDTH'(bus.ovr), ONE64(1'b1));

    // Reset during the third sweep cycle aborts the sweep and clears everything.
    drive_write(M_LOAD, 4, 64'h44);
    tick("load4");
    drive_read(4, 64'h44);
    tick("read4");
    bus.CLR_ALL = 1'b1;
    tick("clr2_start");
    tick("clr2_c1");
    tick("clr2_c2");
    rst_n = 1'b0;
    tick("mid_reset");
    check("mid reset busy", WIDTH'(bus.busy), ZERO);
    check("mid reset q",    bus.q,            ZERO);
    check("mid reset ovr",  WIDTH'(bus.ovr),  ZERO);
    rst_n = 1'b1;
    drive_read(4, ZERO);
    tick("read4_after_reset");
    check("busy stays low", WIDTH'(bus.busy), ZERO);

    // Out-of-range write must be dropped without aliasing onto a real entry.
    drive_write(M_LOAD, 9, 64'hBEEF);
    tick("oob_write");
    check("oob ovr", WIDTH'(bus.ovr), ONE64(1'b1));
    drive_read(1, ZERO);
    tick("read1_after_oob");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
